skinny_inv_sbox_masked: RTL
===========================

Name: skinny_inv_sbox_masked

Overview:
3-share, second-order masked SKINNY-64 inverse 4-bit S-box for the decryption datapath. It is the counterpart of the pipelined masked forward S-box. The block evaluates S^-1 iteratively: four masked quadratic rounds on a 12-bit shared state, with a valid/ready handshake on both sides. Fresh randomness is taken from the shared refresh source at 3 bits per round.

Parameters:
ZERO_IDLE_OUT, 1, when 1, out1/out2/out3 are forced to 0 unless out_valid=1; when 0, they mirror the state register.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input shares valid
in_ready  output  1  block idle and accepting
in1  input  4  share 0 of ciphertext nibble
in2  input  4  share 1
in3  input  4  share 2
r  input  3  fresh randomness, sampled only when r_req=1
r_req  output  1  high in the cycle r is consumed
out_valid  output  1  result shares valid
out_ready  input  1  consumer accepts result
out1  output  4  share 0 of S^-1(x)
out2  output  4  share 1
out3  output  4  share 2

Behaviour:
- Function: (out1^out2^out3) = S^-1(in1^in2^in3). The S^-1 table for 0..F is 3,4,6,8,C,A,1,E,9,2,5,7,0,B,D,F.
- Decomposition: S^-1 = g, then 3x(rotr; g).
  - g: x0 ^= NOR(x3,x2), with all other bits unchanged.
  - rotr: (x3,x2,x1,x0) -> (x0,x3,x2,x1).
  - Each linear op is applied per share.
- Masked g, for share i in {1,2,3}:
  - na_i = x3_i ^ (i==1) and nb_i = x2_i ^ (i==1). The complement is applied on share 1 only.
  - Cross terms are t_ij = na_i & nb_j.
  - MULT cycle registers p_ii = t_ii and p_ij = t_ij ^ r_k. Pair {1,2} uses r[0], {1,3} uses r[1], {2,3} uses r[2]. t_ij and t_ji use the same bit.
  - COMP cycle: x0_i ^= p_ii ^ p_ij ^ p_ik, taking only registered p values.
  - No unregistered cross-domain term may reach the state.
- FSM states: IDLE, MULT, COMP, DONE; a 2-bit round counter k.
- IDLE: in_ready=1.
  - On in_valid=1, load the state from in1..3, set k=0, go to MULT.
- MULT: r_req=1, sample r, register the 9 p terms, go to COMP.
- COMP: compress into x0 shares.
  - If k<3: apply rotr to all shares, k++, go to MULT.
  - If k=3: go to DONE with no rotation.
- DONE: out_valid=1 and outputs = state.
  - When out_ready=1, go to IDLE.
  - Otherwise hold the state and outputs stable.
- Latency: accept in cycle T gives out_valid=1 in cycle T+9. Throughput is 1 nibble per 10 cycles when out_ready is tied high.
- in_ready=0 in all states except IDLE. in_valid while busy is ignored and not buffered.
- r_req pulses exactly 4 times per operation, in cycles T+1, T+3, T+5, T+7.
- The r value is irrelevant outside r_req cycles.
- Reset, any cycle including mid-round:
  - Next cycle the FSM is in IDLE; state, p registers and k are cleared to 0.
  - out_valid=0, r_req=0, in_ready=1, out1..3=0.
  - A partially computed result is never emitted.
- All outputs are registered or decoded from the FSM; there are no combinational paths from inputs to outputs.

Test Plan:
- Shares in1=5, in2=3, in3=A (x=C), r=7 every round, out_ready=1 -> out_valid in cycle T+9 and out1^out2^out3=0.
- All 16 x with random share splits and random r, 200 runs each -> XOR of outputs matches the S^-1 table every run; out_valid exactly 9 cycles after accept.
- r held at 0, x=0 and x=F -> outputs XOR to 3 and F respectively (correct without randomness); r_req count is 4 per operation.
- out_ready low for 5 cycles in DONE, x=7 -> out_valid and shares held constant, in_ready=0; release gives XOR=E, then IDLE next cycle.
- in_valid pulsed with x=2 during COMP of an active x=9 operation -> ignored; single result with XOR=2 (S^-1(9)); no second out_valid.
- rst asserted in MULT of round 2 -> next cycle IDLE with all outputs 0 and in_ready=1; next accepted x=D yields B.

Source files
------------

// File: rtl/skinny_inv_sbox_masked.sv
// Three-share, second-order masked SKINNY-64 inverse S-box.
// S^-1 is evaluated as g, then three times (rotr; g), where g is
// x0 ^= NOR(x3,x2). Each g takes two cycles. MULT registers the nine
// refreshed cross products, and COMP folds the registered terms into
// the x0 shares.
module skinny_inv_sbox_masked #(
    parameter bit ZERO_IDLE_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [2:0] r,
    output logic       r_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_COMP, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0][3:0]  r_x;        // r_x[i] = share i of the nibble
    logic [2:0][2:0]  r_p;        // r_p[i][j] = registered product na_i & nb_j (refreshed)
    logic [1:0]       r_k;        // round counter

    logic [2:0]       w_na;
    logic [2:0]       w_nb;
    logic [2:0][2:0]  w_pm;
    logic [2:0][3:0]  w_g;
    logic [2:0][3:0]  w_rot;

    // Each share pair uses one fresh bit. t_ij and t_ji use the same bit,
    // so the masks cancel when the shares are recombined.
    function automatic logic pair_r(input int i, input int j, input logic [2:0] rr);
        if (i == j)          return 1'b0;
        else if (i + j == 1) return rr[0];
        else if (i + j == 2) return rr[1];
        else                 return rr[2];
    endfunction

    // Masked NOR operands, the refreshed products, and the compressed/rotated next state.
    always_comb begin
        w_na  = '0;
        w_nb  = '0;
        w_pm  = '0;
        w_g   = '0;
        w_rot = '0;
        for (int i = 0; i < 3; i++) begin
            // Complementing only share 0 turns AND of the shared values into NOR.
            w_na[i] = r_x[i][3] ^ (i == 0);
            w_nb[i] = r_x[i][2] ^ (i == 0);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_pm[i][j] = (w_na[i] & w_nb[j]) ^ pair_r(i, j, r);
            end
        end
        for (int i = 0; i < 3; i++) begin
            // Only registered products reach the state here.
            w_g[i]   = {r_x[i][3:1], r_x[i][0] ^ r_p[i][0] ^ r_p[i][1] ^ r_p[i][2]};
            w_rot[i] = {w_g[i][0], w_g[i][3:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_MULT;
            S_MULT: w_state_nxt = S_COMP;
            S_COMP: w_state_nxt = (r_k == 2'd3) ? S_DONE : S_MULT;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load shares, register products, compress and rotate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_p <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x <= {in3, in2, in1};
                        r_k <= 2'd0;
                    end
                end
                S_MULT: r_p <= w_pm;
                S_COMP: begin
                    if (r_k == 2'd3) begin
                        r_x <= w_g;
                    end else begin
                        r_x <= w_rot;
                        r_k <= r_k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign r_req     = (r_state == S_MULT);
    assign out_valid = (r_state == S_DONE);

    // Shares are shown only when valid if zeroing is enabled.
    assign out1 = (ZERO_IDLE_OUT && !out_valid) ? 4'h0 : r_x[0];
    assign out2 = (ZERO_IDLE_OUT && !out_valid) ? 4'h0 : r_x[1];
    assign out3 = (ZERO_IDLE_OUT && !out_valid) ? 4'h0 : r_x[2];

endmodule
